alu_wide_seq: RTL

ALU_WIDE_SEQ -- requirements
Module: alu_wide_seq

---
 rtl/alu_wide_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_wide_seq.sv
// Sequential wide ALU: streams W = N*K bit operands through an external N-bit ALU
// one slice per cycle, chaining carry and zero across slices.
module alu_wide_seq #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op_H,
    input  logic             op_Cin,
    input  logic [N*K-1:0]   op_A,
    input  logic [N*K-1:0]   op_B,
    output logic [N-1:0]     alu_A,
    output logic [N-1:0]     alu_B,
    output logic [2:0]       alu_H,
    output logic             alu_Cin,
    input  logic [N-1:0]     alu_F,
    input  logic [3:0]       alu_flags,
    output logic [N*K-1:0]   res,
    output logic [3:0]       res_flags,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int unsigned W  = N * K;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2:0]      h_q, h_d;
    logic            cin_q, cin_d;
    logic [IW-1:0]   i_q, i_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic [W-1:0]    res_q, res_d;
    logic [3:0]      flags_q, flags_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            h_q     <= '0;
            cin_q   <= 1'b0;
            i_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            h_q     <= h_d;
            cin_q   <= cin_d;
            i_q     <= i_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // Next state: accept in IDLE, one slice per RUN cycle, hold result in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        h_d     = h_q;
        cin_d   = cin_q;
        i_d     = i_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        res_d   = res_q;
        flags_d = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d     = op_A;
                    b_d     = op_B;
                    h_d     = op_H;
                    cin_d   = op_Cin;
                    i_d     = '0;
                    res_d   = '0;
                    zero_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[i_q*N +: N] = alu_F;
                carry_d           = alu_flags[0];
                zero_d            = zero_q & alu_flags[1];
                if (i_q == IW'(K - 1)) begin
                    flags_d = {alu_flags[3], alu_flags[2], zero_q & alu_flags[1], alu_flags[0]};
                    state_d = S_DONE;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slice drive to the external ALU; quiet outside RUN.
    always_comb begin
        alu_A   = '0;
        alu_B   = '0;
        alu_H   = '0;
        alu_Cin = 1'b0;
        if (state_q == S_RUN) begin
            alu_A   = a_q[i_q*N +: N];
            alu_B   = b_q[i_q*N +: N];
            alu_H   = h_q;
            alu_Cin = (i_q == '0) ? cin_q : carry_q;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign res         = res_q;
    assign res_flags   = flags_q;

endmodule
